booth_mul64_seq: RTL and testbench

//  Sequential radix-2 Booth multiplier, 64x64 signed -> 128-bit product.

---
 rtl/booth_mul64_seq.sv | 155 +++++++++++++++
 tb/tb_booth_mul64_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/booth_mul64_seq.sv
// Sequential radix-2 Booth multiplier, 64x64 signed -> 128-bit signed product.
// Each EXEC cycle performs one add/subtract/pass through a 65-bit CLA, then
// shifts {A, Q, q_m1} right by one arithmetically. 64 iterations per product.

// 65-bit carry-lookahead adder: 16 four-bit lookahead groups plus a top bit.
module cla65 (
  input  logic [64:0] a,
  input  logic [64:0] b,
  input  logic        ci,
  output logic [64:0] s,
  output logic        co
);
  logic [64:0] w_g;
  logic [64:0] w_p;
  logic [16:0] w_gc;   // carry into each 4-bit group; w_gc[16] feeds bit 64

  assign w_g     = a & b;
  assign w_p     = a ^ b;
  assign w_gc[0] = ci;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi = gi + 1) begin : g_grp
      logic [3:0] w_gg;
      logic [3:0] w_pp;
      logic [3:0] w_c;   // carry into each bit of this group
      logic       c_in;

      assign w_gg = w_g[4*gi +: 4];
      assign w_pp = w_p[4*gi +: 4];
      assign c_in = w_gc[gi];

      // Full lookahead inside the group, group carries ripple between groups.
      assign w_c[0] = c_in;
      assign w_c[1] = w_gg[0] | (w_pp[0] & c_in);
      assign w_c[2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & c_in);
      assign w_c[3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                    | (w_pp[2] & w_pp[1] & w_pp[0] & c_in);
      assign w_gc[gi+1] = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                        | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0])
                        | (w_pp[3] & w_pp[2] & w_pp[1] & w_pp[0] & c_in);

      assign s[4*gi +: 4] = w_pp ^ w_c;
    end
  endgenerate

  assign s[64] = w_p[64] ^ w_gc[16];
  assign co    = w_g[64] | (w_p[64] & w_gc[16]);
endmodule

module booth_mul64_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_start,
  input  logic         op_clear,
  input  logic [63:0]  multiplicand,
  input  logic [63:0]  multiplier,
  output logic         op_done,
  output logic [127:0] result
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   r_state;
  logic [64:0]  r_a;       // 65 bits so A-M with M=-2^63 cannot overflow
  logic [63:0]  r_q;
  logic         r_qm1;
  logic [64:0]  r_m;       // sign-extended multiplicand
  logic [6:0]   r_count;
  logic [127:0] r_result;

  logic [64:0]  w_b;
  logic         w_ci;
  logic [64:0]  w_sum;
  logic         w_cla_co_unused;
  logic [64:0]  w_a_shift;
  logic [63:0]  w_q_shift;

  // Booth decode of {Q[0], q_m1}: select +M, -M (~M with carry-in) or zero.
  always_comb begin
    w_b  = 65'd0;
    w_ci = 1'b0;
    case ({r_q[0], r_qm1})
      2'b01:   w_b = r_m;
      2'b10: begin
        w_b  = ~r_m;
        w_ci = 1'b1;
      end
      default: begin
        w_b  = 65'd0;
        w_ci = 1'b0;
      end
    endcase
  end

  cla65 u_cla (
    .a  (r_a),
    .b  (w_b),
    .ci (w_ci),
    .s  (w_sum),
    .co (w_cla_co_unused)
  );

  // Arithmetic right shift of {A', Q} with the sign bit of A' replicated.
  assign w_a_shift = {w_sum[64], w_sum[64:1]};
  assign w_q_shift = {w_sum[0], r_q[63:1]};

  // Control FSM and datapath registers; clear has priority over start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= 65'd0;
      r_q      <= 64'd0;
      r_qm1    <= 1'b0;
      r_m      <= 65'd0;
      r_count  <= 7'd0;
      r_result <= 128'd0;
    end else if (op_clear) begin
      r_state  <= S_IDLE;
      r_a      <= 65'd0;
      r_q      <= 64'd0;
      r_qm1    <= 1'b0;
      r_count  <= 7'd0;
      r_result <= 128'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (op_start) begin
            r_m     <= {multiplicand[63], multiplicand};
            r_q     <= multiplier;
            r_a     <= 65'd0;
            r_qm1   <= 1'b0;
            r_count <= 7'd0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_a     <= w_a_shift;
          r_q     <= w_q_shift;
          r_qm1   <= r_q[0];
          r_count <= r_count + 7'd1;
          if (r_count == 7'd63) begin
            r_result <= {w_a_shift[63:0], w_q_shift};
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_done = (r_state == S_DONE);
  assign result  = r_result;
endmodule

// File: tb/tb_booth_mul64_seq.sv
// Directed bench for booth_mul64_seq: products, latency, restart from DONE,
// ignored start during EXEC, synchronous clear and asynchronous reset.
module tb_booth_mul64_seq;
  logic         clk = 1'b0;
  logic         reset;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  multiplicand;
  logic [63:0]  multiplier;
  logic         op_done;
  logic [127:0] result;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit stable;

  booth_mul64_seq dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_done      (op_done),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands with op_start for one edge; returns #1 after that edge.
  task automatic start_op(input logic [63:0] m, input logic [63:0] q);
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    op_start     = 1'b1;
    @(posedge clk);
    #1;
    op_start     = 1'b0;
  endtask

  // Count edges until op_done, bounded; also note whether result ever moved.
  task automatic run_to_done(input logic [127:0] held, input int limit,
                             output int n, output bit st);
    n  = 0;
    st = 1'b1;
    while (op_done !== 1'b1 && n < limit) begin
      if (result !== held) st = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    reset        = 1'b1;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplicand = 64'd0;
    multiplier   = 64'd0;
    #1;
    chk("rst_done", 128'(op_done), 128'd0);
    chk("rst_result", result, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: 3*5, latency exactly 64 edges after acceptance
    start_op(64'd3, 64'd5);
    chk("t1_busy", 128'(op_done), 128'd0);
    run_to_done(128'd0, 200, cyc, stable);
    chk("t1_latency", 128'(cyc), 128'd64);
    chk("t1_stable", 128'(stable), 128'd1);
    chk("t1_result", result, 128'h0000_0000_0000_0000_0000_0000_0000_000F);
    $display("t1 3*5 result=%h cycles=%0d", result, cyc);

    // 2: -7*3 = -21
    start_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd3);
    run_to_done(128'h0000_0000_0000_0000_0000_0000_0000_000F, 200, cyc, stable);
    chk("t2_latency", 128'(cyc), 128'd64);
    chk("t2_stable", 128'(stable), 128'd1);
    chk("t2_result", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB);
    $display("t2 -7*3 result=%h", result);

    // 3: -2^63 squared = 2^126
    start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    run_to_done(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB, 200, cyc, stable);
    chk("t3_latency", 128'(cyc), 128'd64);
    chk("t3_result", result, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    $display("t3 min*min result=%h", result);

    // 3b: (2^63-1) * -2^63 = -2^126 + 2^63
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    run_to_done(128'h4000_0000_0000_0000_0000_0000_0000_0000, 200, cyc, stable);
    chk("t3b_result", result, 128'hC000_0000_0000_0000_8000_0000_0000_0000);
    $display("t3b max*min result=%h", result);

    // 6: async reset between edges mid-EXEC, then 6*7
    start_op(64'd5, 64'd5);
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_done", 128'(op_done), 128'd0);
    chk("t6_rst_result", result, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    start_op(64'd6, 64'd7);
    run_to_done(128'd0, 200, cyc, stable);
    chk("t6_latency", 128'(cyc), 128'd64);
    chk("t6_stable", 128'(stable), 128'd1);
    chk("t6_result", result, 128'd42);
    $display("t6 reset then 6*7 result=%h", result);

    // 4: -1*-1, then restart from DONE with 2*2
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run_to_done(128'd42, 200, cyc, stable);
    chk("t4_result1", result, 128'd1);
    start_op(64'd2, 64'd2);
    chk("t4_done_drop", 128'(op_done), 128'd0);
    chk("t4_held", result, 128'd1);
    run_to_done(128'd1, 200, cyc, stable);
    chk("t4_latency", 128'(cyc), 128'd64);
    chk("t4_stable", 128'(stable), 128'd1);
    chk("t4_result2", result, 128'd4);
    $display("t4 -1*-1 then 2*2 result=%h", result);

    // 5a: op_start during EXEC is ignored (3*5 continues, 9*9 dropped)
    start_op(64'd3, 64'd5);
    repeat (10) @(posedge clk);
    start_op(64'd9, 64'd9);
    run_to_done(128'd4, 200, cyc, stable);
    chk("t5_ign_latency", 128'(cyc), 128'd53);
    chk("t5_ign_result", result, 128'd15);
    $display("t5a ignored start result=%h", result);

    // 5b: op_clear at EXEC cycle 20 returns to IDLE with zeroed result
    start_op(64'd7, 64'd7);
    repeat (19) @(posedge clk);
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    op_clear = 1'b0;
    chk("t5_clr_done", 128'(op_done), 128'd0);
    chk("t5_clr_result", result, 128'd0);
    run_to_done(128'd0, 80, cyc, stable);
    chk("t5_idle_cycles", 128'(cyc), 128'd80);
    chk("t5_idle_stable", 128'(stable), 128'd1);
    $display("t5b clear result=%h idle_cycles=%0d", result, cyc);

    // 5c: normal op after clear, 100 * -100 = -10000
    start_op(64'd100, 64'hFFFF_FFFF_FFFF_FF9C);
    run_to_done(128'd0, 200, cyc, stable);
    chk("t5_post_latency", 128'(cyc), 128'd64);
    chk("t5_post_result", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_D8F0);
    $display("t5c 100*-100 result=%h", result);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
